// File: rtl/sprite_locator.sv
// sprite_locator: double-buffered sprite object table and per-pixel hit search.
// Optional collision counter enabled with macro SPRITE_COLLISION_EN.
module sprite_locator #(
  parameter int NUM_SPRITES = 8,
  parameter int SCALE_SHIFT = 1,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_slot,
  input  logic [9:0]  i_wr_x,
  input  logic [9:0]  i_wr_y,
  input  logic [5:0]  i_wr_num,
  input  logic        i_wr_vis,
  input  logic [9:0]  i_column,
  input  logic [9:0]  i_row,
  output logic [5:0]  o_sprite_num,
  output logic [2:0]  o_row_num,
  output logic [2:0]  o_col_num,
  output logic        o_hit,
  output logic        o_pending,
  output logic [15:0] o_collisions
);

  localparam logic [9:0] LP_S = 10'(8 << SCALE_SHIFT);
  localparam logic [9:0] LP_H = 10'(H_ACTIVE);
  localparam logic [9:0] LP_V = 10'(V_ACTIVE);
  localparam logic [4:0] LP_N = 5'(NUM_SPRITES);

  logic [9:0] r_pend_x   [NUM_SPRITES];
  logic [9:0] r_pend_y   [NUM_SPRITES];
  logic [5:0] r_pend_num [NUM_SPRITES];
  logic       r_pend_vis [NUM_SPRITES];
  logic [9:0] r_act_x    [NUM_SPRITES];
  logic [9:0] r_act_y    [NUM_SPRITES];
  logic [5:0] r_act_num  [NUM_SPRITES];
  logic       r_act_vis  [NUM_SPRITES];

  logic       r_pending;
  logic [5:0] r_sprite_num;
  logic [2:0] r_row_num;
  logic [2:0] r_col_num;
  logic       r_hit1;
  logic       r_hit2;

  logic       w_wr;
  logic       w_commit;
  logic       w_area;
  logic       w_hit;
  logic [5:0] w_num;
  logic [2:0] w_row;
  logic [2:0] w_col;
  logic [9:0] w_kdx;
  logic [9:0] w_kdy;
`ifdef SPRITE_COLLISION_EN
  logic       w_multi;
  logic [15:0] r_coll_cnt;
  logic [15:0] r_collisions;
`endif

  assign w_wr     = i_wr_en && ({1'b0, i_wr_slot} < LP_N);
  assign w_commit = (i_column == 10'd0) && (i_row == LP_V);
  assign w_area   = (i_column < LP_H) && (i_row < LP_V);

  // Search slots high to low so the lowest-numbered hit is the last one kept.
  always_comb begin
    w_hit = 1'b0;
    w_num = '0;
    w_row = '0;
    w_col = '0;
    w_kdx = '0;
    w_kdy = '0;
`ifdef SPRITE_COLLISION_EN
    w_multi = 1'b0;
`endif
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      w_kdx = i_column - r_act_x[k];
      w_kdy = i_row - r_act_y[k];
      if (r_act_vis[k] && (w_kdx < LP_S) && (w_kdy < LP_S) && w_area) begin
`ifdef SPRITE_COLLISION_EN
        if (w_hit) w_multi = 1'b1;
`endif
        w_hit = 1'b1;
        w_num = r_act_num[k];
        w_row = w_kdy[SCALE_SHIFT+2 -: 3];
        w_col = w_kdx[SCALE_SHIFT+2 -: 3];
      end
    end
  end

  // Pending table takes writes; active table is copied from it only at vblank start.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        r_pend_x[k]   <= '0;
        r_pend_y[k]   <= '0;
        r_pend_num[k] <= '0;
        r_pend_vis[k] <= 1'b0;
        r_act_x[k]    <= '0;
        r_act_y[k]    <= '0;
        r_act_num[k]  <= '0;
        r_act_vis[k]  <= 1'b0;
      end
      r_pending <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        if (w_commit) begin
          r_act_x[k]   <= r_pend_x[k];
          r_act_y[k]   <= r_pend_y[k];
          r_act_num[k] <= r_pend_num[k];
          r_act_vis[k] <= r_pend_vis[k];
        end
        if (w_wr && (i_wr_slot == 4'(k))) begin
          r_pend_x[k]   <= i_wr_x;
          r_pend_y[k]   <= i_wr_y;
          r_pend_num[k] <= i_wr_num;
          r_pend_vis[k] <= i_wr_vis;
        end
      end
      if (w_wr)
        r_pending <= 1'b1;
      else if (w_commit)
        r_pending <= 1'b0;
    end
  end

  // Stage 1 registers the ROM address, stage 2 delays the hit to match ROM output.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sprite_num <= '0;
      r_row_num    <= '0;
      r_col_num    <= '0;
      r_hit1       <= 1'b0;
      r_hit2       <= 1'b0;
    end else begin
      r_sprite_num <= w_num;
      r_row_num    <= w_row;
      r_col_num    <= w_col;
      r_hit1       <= w_hit;
      r_hit2       <= r_hit1;
    end
  end

`ifdef SPRITE_COLLISION_EN
  // Saturating per-frame overlap count, published and cleared at vblank start.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_coll_cnt   <= '0;
      r_collisions <= '0;
    end else if (w_commit) begin
      r_collisions <= r_coll_cnt;
      r_coll_cnt   <= '0;
    end else if (w_multi && (r_coll_cnt != 16'hFFFF)) begin
      r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  assign o_collisions = r_collisions;
`else
  assign o_collisions = '0;
`endif

  assign o_sprite_num = r_sprite_num;
  assign o_row_num    = r_row_num;
  assign o_col_num    = r_col_num;
  assign o_hit        = r_hit2;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_sprite_locator.sv
// tb_sprite_locator: directed vectors with hand-computed expectations.
// Collision count expectation follows SPRITE_COLLISION_EN.
module tb_sprite_locator;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_wr_en;
  logic [3:0]  i_wr_slot;
  logic [9:0]  i_wr_x;
  logic [9:0]  i_wr_y;
  logic [5:0]  i_wr_num;
  logic        i_wr_vis;
  logic [9:0]  i_column;
  logic [9:0]  i_row;
  logic [5:0]  o_sprite_num;
  logic [2:0]  o_row_num;
  logic [2:0]  o_col_num;
  logic        o_hit;
  logic        o_pending;
  logic [15:0] o_collisions;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_locator dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_wr_en      (i_wr_en),
    .i_wr_slot    (i_wr_slot),
    .i_wr_x       (i_wr_x),
    .i_wr_y       (i_wr_y),
    .i_wr_num     (i_wr_num),
    .i_wr_vis     (i_wr_vis),
    .i_column     (i_column),
    .i_row        (i_row),
    .o_sprite_num (o_sprite_num),
    .o_row_num    (o_row_num),
    .o_col_num    (o_col_num),
    .o_hit        (o_hit),
    .o_pending    (o_pending),
    .o_collisions (o_collisions)
  );

  always #20 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle_beam();
    i_column = 10'd700;
    i_row    = 10'd10;
  endtask

  task automatic wr(input logic [3:0] s, input logic [9:0] x,
                    input logic [9:0] y, input logic [5:0] n,
                    input logic v);
    i_wr_en   = 1'b1;
    i_wr_slot = s;
    i_wr_x    = x;
    i_wr_y    = y;
    i_wr_num  = n;
    i_wr_vis  = v;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic commit();
    i_column = 10'd0;
    i_row    = 10'd480;
    tick();
    idle_beam();
  endtask

  task automatic probe(input string tag, input logic [9:0] c,
                       input logic [9:0] r, input logic [5:0] en,
                       input logic [2:0] er, input logic [2:0] ec,
                       input logic eh);
    i_column = c;
    i_row    = r;
    tick();
    chk({tag, ".num"}, 32'(o_sprite_num), 32'(en));
    chk({tag, ".row"}, 32'(o_row_num), 32'(er));
    chk({tag, ".col"}, 32'(o_col_num), 32'(ec));
    idle_beam();
    tick();
    chk({tag, ".hit"}, 32'(o_hit), 32'(eh));
  endtask

  initial begin
    i_Reset = 1'b1;
    i_wr_en = 1'b0;
    i_wr_slot = '0;
    i_wr_x = '0;
    i_wr_y = '0;
    i_wr_num = '0;
    i_wr_vis = 1'b0;
    idle_beam();
    tick();
    tick();
    chk("rst.num", 32'(o_sprite_num), 0);
    chk("rst.row", 32'(o_row_num), 0);
    chk("rst.col", 32'(o_col_num), 0);
    chk("rst.hit", 32'(o_hit), 0);
    chk("rst.pend", 32'(o_pending), 0);
    chk("rst.coll", 32'(o_collisions), 0);
    i_Reset = 1'b0;

    // Empty table: nothing ever hits.
    for (int r = 0; r < 480; r += 159) begin
      for (int c = 0; c < 640; c++) begin
        i_column = 10'(c);
        i_row    = 10'(r);
        tick();
        chk("empty.out", {25'd0, o_hit, o_sprite_num},
            32'd0);
      end
    end
    idle_beam();
    tick();
    chk("empty.pend", 32'(o_pending), 0);

    // Single sprite, visible only after commit.
    wr(4'd0, 10'd100, 10'd50, 6'd5, 1'b1);
    chk("wr0.pend", 32'(o_pending), 1);
    probe("precommit", 10'd100, 10'd50, 6'd0, 3'd0, 3'd0, 1'b0);
    commit();
    chk("cm0.pend", 32'(o_pending), 0);
    probe("tl", 10'd100, 10'd50, 6'd5, 3'd0, 3'd0, 1'b1);
    probe("br", 10'd115, 10'd65, 6'd5, 3'd7, 3'd7, 1'b1);
    probe("right", 10'd116, 10'd50, 6'd0, 3'd0, 3'd0, 1'b0);
    probe("left", 10'd99, 10'd50, 6'd0, 3'd0, 3'd0, 1'b0);
    probe("below", 10'd100, 10'd66, 6'd0, 3'd0, 3'd0, 1'b0);

    // Overlapping pair: count overlap pixels, then check priority.
    wr(4'd1, 10'd104, 10'd50, 6'd9, 1'b1);
    commit();
    for (int r = 48; r < 68; r++) begin
      for (int c = 96; c < 124; c++) begin
        i_column = 10'(c);
        i_row    = 10'(r);
        tick();
      end
    end
    idle_beam();
    commit();
`ifdef SPRITE_COLLISION_EN
    chk("coll", 32'(o_collisions), 192);
`else
    chk("coll", 32'(o_collisions), 0);
`endif
    probe("prio", 10'd108, 10'd52, 6'd5, 3'd1, 3'd4, 1'b1);
    probe("slot1", 10'd117, 10'd50, 6'd9, 3'd0, 3'd6, 1'b1);

    // Horizontal wrap-around.
    wr(4'd2, 10'd1020, 10'd200, 6'd3, 1'b1);
    commit();
    probe("wrap.off", 10'd1020, 10'd200, 6'd0, 3'd0, 3'd0, 1'b0);
    probe("wrap.c0", 10'd0, 10'd200, 6'd3, 3'd0, 3'd2, 1'b1);
    probe("wrap.c11", 10'd11, 10'd205, 6'd3, 3'd2, 3'd7, 1'b1);
    probe("wrap.c12", 10'd12, 10'd200, 6'd0, 3'd0, 3'd0, 1'b0);

    // Write landing in the commit cycle.
    i_column  = 10'd0;
    i_row     = 10'd480;
    i_wr_en   = 1'b1;
    i_wr_slot = 4'd0;
    i_wr_x    = 10'd100;
    i_wr_y    = 10'd50;
    i_wr_num  = 6'd20;
    i_wr_vis  = 1'b1;
    tick();
    i_wr_en = 1'b0;
    idle_beam();
    chk("wc.pend", 32'(o_pending), 1);
    probe("wc.old", 10'd100, 10'd50, 6'd5, 3'd0, 3'd0, 1'b1);
    chk("wc.pend2", 32'(o_pending), 1);
    commit();
    chk("wc.pend3", 32'(o_pending), 0);
    probe("wc.new", 10'd100, 10'd50, 6'd20, 3'd0, 3'd0, 1'b1);

    // Mid-frame reset with a sprite under the beam.
    i_column = 10'd100;
    i_row    = 10'd50;
    tick();
    i_Reset = 1'b1;
    tick();
    chk("mrst.num", 32'(o_sprite_num), 0);
    chk("mrst.hit", 32'(o_hit), 0);
    chk("mrst.pend", 32'(o_pending), 0);
    tick();
    i_Reset = 1'b0;
    chk("mrst.coll", 32'(o_collisions), 0);
    probe("mrst.tbl", 10'd100, 10'd50, 6'd0, 3'd0, 3'd0, 1'b0);
    wr(4'd8, 10'd100, 10'd50, 6'd7, 1'b1);
    chk("slot8.pend", 32'(o_pending), 0);
    commit();
    probe("slot8.tbl", 10'd100, 10'd50, 6'd0, 3'd0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
